// File: rtl/sdp_y_dma_pkg.sv
// rtl/sdp_y_dma_pkg.sv - shared types and constants for the Y-path DMA write request generator
package sdp_y_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic REQ_TYPE_CMD  = 1'b0;
  localparam logic REQ_TYPE_DATA = 1'b1;

  localparam int BEAT_BYTES = 8;

  // Command beat layout: address at the bottom, size directly above it, last_req at the top bit.
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_LAST_BIT = 63;

endpackage

// File: rtl/sdp_y_dma_wr_req_gen_if.sv
// rtl/sdp_y_dma_wr_req_gen_if.sv - input beat stream and DMA write request channel
interface sdp_y_dma_wr_req_gen_if #(
  parameter int DW = 64
);

  logic          inp_pvld;
  logic          inp_prdy;
  logic [DW-1:0] inp_data;

  logic          dma_wr_req_pvld;
  logic          dma_wr_req_prdy;
  logic          dma_wr_req_type;
  logic [DW-1:0] dma_wr_req_pd;

  modport master (
    input  inp_pvld,
    input  inp_data,
    output inp_prdy,
    output dma_wr_req_pvld,
    input  dma_wr_req_prdy,
    output dma_wr_req_type,
    output dma_wr_req_pd
  );

  modport slave (
    output inp_pvld,
    output inp_data,
    input  inp_prdy,
    input  dma_wr_req_pvld,
    output dma_wr_req_prdy,
    input  dma_wr_req_type,
    input  dma_wr_req_pd
  );

endinterface

// File: rtl/sdp_y_dma_wr_req_gen.sv
// rtl/sdp_y_dma_wr_req_gen.sv - walks a 2-D surface and emits burst command beats followed by pass-through data beats
module sdp_y_dma_wr_req_gen
  import sdp_y_dma_pkg::*;
#(
  parameter int AW        = 40,
  parameter int DW        = 64,
  parameter int LENW      = 13,
  parameter int MAX_BURST = 8
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  op_en,
  input  logic [AW-1:0]         cfg_base_addr,
  input  logic [AW-1:0]         cfg_line_stride,
  input  logic [LENW-1:0]       cfg_width,
  input  logic [LENW-1:0]       cfg_height,
  sdp_y_dma_wr_req_gen_if.master bus,
  output logic                  busy,
  output logic                  op_done
);

  localparam logic [LENW:0] MAX_BEATS = (LENW+1)'(MAX_BURST);
  localparam logic [LENW:0] ONE       = (LENW+1)'(1);

  state_t state, state_nxt;

  logic [LENW-1:0] width_r, height_r, line_idx;
  logic [AW-1:0]   stride_r, line_base, cur_addr;
  logic [LENW:0]   rem;
  logic [LENW:0]   beat_cnt;

  logic [LENW:0]   burst_beats;
  logic [LENW-1:0] burst_size;
  logic            last_line, line_end, last_req, burst_last_beat;
  logic            cmd_fire, data_fire;
  logic [DW-1:0]   cmd_pd;

  // rem only moves at burst end, so the burst length is stable for the whole CMD+DATA span.
  assign burst_beats     = (rem > MAX_BEATS) ? MAX_BEATS : rem;
  assign burst_size      = LENW'(burst_beats - ONE);
  assign last_line       = (line_idx == height_r);
  assign line_end        = (rem == burst_beats);
  assign last_req        = last_line && line_end;
  assign burst_last_beat = (beat_cnt == burst_beats - ONE);

  assign cmd_fire  = (state == ST_CMD) && bus.dma_wr_req_prdy;
  assign data_fire = (state == ST_DATA) && bus.inp_pvld && bus.dma_wr_req_prdy;

  always_comb begin
    cmd_pd                           = '0;
    cmd_pd[CMD_ADDR_LSB +: AW]       = cur_addr;
    cmd_pd[AW +: LENW]               = burst_size;
    cmd_pd[CMD_LAST_BIT]             = last_req;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    bus.inp_prdy        = 1'b0;
    bus.dma_wr_req_pvld = 1'b0;
    bus.dma_wr_req_type = REQ_TYPE_CMD;
    bus.dma_wr_req_pd   = '0;
    case (state)
      ST_IDLE: begin
        if (op_en) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        bus.dma_wr_req_pvld = 1'b1;
        bus.dma_wr_req_pd   = cmd_pd;
        if (bus.dma_wr_req_prdy) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        bus.dma_wr_req_pvld = bus.inp_pvld;
        bus.inp_prdy        = bus.dma_wr_req_prdy;
        bus.dma_wr_req_type = REQ_TYPE_DATA;
        bus.dma_wr_req_pd   = bus.inp_data;
        if (data_fire && burst_last_beat) state_nxt = last_req ? ST_DONE : ST_CMD;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      width_r   <= '0;
      height_r  <= '0;
      stride_r  <= '0;
      line_base <= '0;
      cur_addr  <= '0;
      line_idx  <= '0;
      rem       <= '0;
      beat_cnt  <= '0;
    end else if (state == ST_IDLE) begin
      if (op_en) begin
        width_r   <= cfg_width;
        height_r  <= cfg_height;
        stride_r  <= cfg_line_stride;
        line_base <= cfg_base_addr;
        cur_addr  <= cfg_base_addr;
        line_idx  <= '0;
        rem       <= {1'b0, cfg_width} + ONE;
        beat_cnt  <= '0;
      end
    end else if (cmd_fire) begin
      beat_cnt <= '0;
    end else if (data_fire) begin
      beat_cnt <= beat_cnt + ONE;
      if (burst_last_beat) begin
        if (!line_end) begin
          rem      <= rem - burst_beats;
          cur_addr <= cur_addr + AW'(32'(burst_beats) * BEAT_BYTES);
        end else if (!last_line) begin
          // Next line restarts from the previous line start, not from where the bursts ended.
          line_idx  <= line_idx + LENW'(1);
          line_base <= line_base + stride_r;
          cur_addr  <= line_base + stride_r;
          rem       <= {1'b0, width_r} + ONE;
        end
      end
    end
  end

  assign busy    = (state != ST_IDLE);
  assign op_done = (state == ST_DONE);

endmodule

// File: tb/tb_sdp_y_dma_wr_req_gen.sv
// tb/tb_sdp_y_dma_wr_req_gen.sv - table-driven and randomized bench for the Y-path DMA write request generator
module tb_sdp_y_dma_wr_req_gen;

  localparam int AW = 40;
  localparam int DW = 64;
  localparam int LENW = 13;
  localparam int MAXB = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            op_en = 1'b0;
  logic [AW-1:0]   cfg_base_addr = '0;
  logic [AW-1:0]   cfg_line_stride = '0;
  logic [LENW-1:0] cfg_width = '0;
  logic [LENW-1:0] cfg_height = '0;
  logic            busy, op_done;

  sdp_y_dma_wr_req_gen_if #(.DW(DW)) bus ();

  sdp_y_dma_wr_req_gen #(.AW(AW), .DW(DW), .LENW(LENW), .MAX_BURST(MAXB)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .op_en           (op_en),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_line_stride (cfg_line_stride),
    .cfg_width       (cfg_width),
    .cfg_height      (cfg_height),
    .bus             (bus),
    .busy            (busy),
    .op_done         (op_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    int            width;
    int            height;
    int            prdy_pct;
    int            vld_pct;
    bit            noise;
    int            exp_ncmd;
    logic [AW-1:0] exp_last_addr;
  } vec_t;

  typedef struct {
    bit          is_data;
    logic [63:0] pd;
  } exp_t;

  vec_t        tbl[7];
  exp_t        exp_q[$];
  logic [63:0] pool[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference stream: every burst of every line, addresses from line*stride + offset*8 modulo 2^AW.
  task automatic build_expected(input vec_t v);
    int beats;
    logic [AW-1:0] a;
    bit last;
    exp_q.delete();
    pool.delete();
    for (int l = 0; l <= v.height; l++) begin
      for (int o = 0; o <= v.width; o += MAXB) begin
        beats = (v.width + 1 - o < MAXB) ? v.width + 1 - o : MAXB;
        a = v.base + AW'(l) * v.stride + AW'(o) * AW'(8);
        last = (l == v.height) && (o + beats == v.width + 1);
        exp_q.push_back('{1'b0, {last, 10'b0, 13'(beats - 1), a}});
        for (int b = 0; b < beats; b++) begin
          pool.push_back({$urandom, $urandom});
          exp_q.push_back('{1'b1, pool[pool.size() - 1]});
        end
      end
    end
  endtask

  task automatic run_case(input int ci);
    vec_t v;
    exp_t e;
    int ncmd = 0;
    int cyc = 0;
    int src = 0;
    logic [AW-1:0] last_addr = '0;
    v = tbl[ci];
    build_expected(v);
    op_en = 1'b1;
    cfg_base_addr = v.base;
    cfg_line_stride = v.stride;
    cfg_width = LENW'(v.width);
    cfg_height = LENW'(v.height);
    bus.inp_pvld = 1'b0;
    bus.dma_wr_req_prdy = 1'b0;
    @(negedge clk);
    op_en = 1'b0;
    cfg_base_addr = AW'({$urandom, $urandom});
    cfg_width = LENW'($urandom);
    cfg_height = LENW'($urandom);
    while (exp_q.size() > 0 && cyc < 3000) begin
      bus.dma_wr_req_prdy = (int'($urandom_range(0, 99)) < v.prdy_pct);
      bus.inp_pvld = (int'($urandom_range(0, 99)) < v.vld_pct);
      bus.inp_data = (src < pool.size()) ? pool[src] : 64'h0;
      op_en = v.noise && (exp_q.size() > 1) && ($urandom_range(0, 3) == 0);
      if (op_en) begin
        cfg_base_addr = AW'({$urandom, $urandom});
        cfg_width = LENW'($urandom_range(0, 40));
        cfg_height = LENW'($urandom_range(0, 4));
      end
      #1;
      e = exp_q[0];
      if (!e.is_data) begin
        check("cmd_vld", 64'(bus.dma_wr_req_pvld), 64'd1);
        check("cmd_type", 64'(bus.dma_wr_req_type), 64'd0);
        check("cmd_pd", bus.dma_wr_req_pd, e.pd);
        check("cmd_inp_prdy", 64'(bus.inp_prdy), 64'd0);
      end else begin
        check("data_vld", 64'(bus.dma_wr_req_pvld), 64'(bus.inp_pvld));
        check("data_inp_prdy", 64'(bus.inp_prdy), 64'(bus.dma_wr_req_prdy));
        if (bus.dma_wr_req_pvld) begin
          check("data_type", 64'(bus.dma_wr_req_type), 64'd1);
          check("data_pd", bus.dma_wr_req_pd, e.pd);
        end
      end
      check("busy_run", 64'(busy), 64'd1);
      check("op_done_early", 64'(op_done), 64'd0);
      if (bus.dma_wr_req_pvld && bus.dma_wr_req_prdy) begin
        void'(exp_q.pop_front());
        if (e.is_data) src++;
        else begin
          ncmd++;
          last_addr = e.pd[AW-1:0];
        end
      end
      @(negedge clk);
      cyc++;
    end
    op_en = 1'b0;
    bus.inp_pvld = 1'b0;
    bus.dma_wr_req_prdy = 1'b0;
    check("stream_complete", 64'(exp_q.size()), 64'd0);
    #1;
    check("op_done_pulse", 64'(op_done), 64'd1);
    check("busy_done", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    check("op_done_single", 64'(op_done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("cmd_count", 64'(ncmd), 64'(v.exp_ncmd));
    check("last_cmd_addr", 64'(last_addr), 64'(v.exp_last_addr));
    if (exp_q.size() != 0) begin
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{40'h1000, 40'h0,   3,  0, 100, 100, 1'b0, 1, 40'h1000};
    tbl[1] = '{40'h1000, 40'h0,   19, 0, 100, 100, 1'b0, 3, 40'h1080};
    tbl[2] = '{40'h1000, 40'h200, 7,  1, 100, 100, 1'b0, 2, 40'h1200};
    tbl[3] = '{40'h2000, 40'h100, 19, 2, 50,  70,  1'b1, 9, 40'h2280};
    tbl[4] = '{40'h3000, 40'h40,  0,  2, 50,  100, 1'b0, 3, 40'h3080};
    tbl[5] = '{40'h4000, 40'h80,  15, 1, 70,  80,  1'b1, 4, 40'h40c0};
    tbl[6] = '{40'hff_ffff_ffe0, 40'h40, 7, 1, 100, 100, 1'b0, 2, 40'h20};

    bus.inp_pvld = 1'b1;
    bus.inp_data = 64'h0;
    bus.dma_wr_req_prdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_vld", 64'(bus.dma_wr_req_pvld), 64'd0);
    check("rst_inp_prdy", 64'(bus.inp_prdy), 64'd0);
    check("rst_op_done", 64'(op_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_vld", 64'(bus.dma_wr_req_pvld), 64'd0);
    check("idle_inp_prdy", 64'(bus.inp_prdy), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_case(i);

    // Reset in the middle of a burst: everything drops at once and no completion is reported.
    op_en = 1'b1;
    cfg_base_addr = 40'h1000;
    cfg_line_stride = 40'h0;
    cfg_width = LENW'(19);
    cfg_height = '0;
    @(negedge clk);
    op_en = 1'b0;
    bus.inp_pvld = 1'b1;
    bus.inp_data = 64'hdead_beef_0000_0001;
    bus.dma_wr_req_prdy = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("mid_in_data", 64'(bus.dma_wr_req_type), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_vld", 64'(bus.dma_wr_req_pvld), 64'd0);
    check("arst_inp_prdy", 64'(bus.inp_prdy), 64'd0);
    check("arst_op_done", 64'(op_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_op_done", 64'(op_done), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_vld", 64'(bus.dma_wr_req_pvld), 64'd0);
      @(negedge clk);
    end
    run_case(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
